// File: rtl/mips_pkg.sv
// mips_pkg: widths and constants shared by the register file and pipeline stage registers
package mips_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/reg_bypass_mux.sv
// reg_bypass_mux: per-read-port selection between stored data and same-cycle write-back data
module reg_bypass_mux
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic hit;
  // forward write-back data on an index match; r0 is never forwarded and reset forces zero
  always_comb begin
    hit       = wb_en_i && (wb_addr_i != ADDR_W'(ZERO_REG)) && (rd_addr_i == wb_addr_i);
    rd_data_o = !rst ? '0 : hit ? wb_data_i : rf_data_i;
  end
endmodule

// File: rtl/reg_file.sv
// reg_file: 2-read/1-write register file with r0 hardwired to zero, write-back bypass and write counter
module reg_file
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_data_in,
  input  logic              wb_write_en_in,
  input  logic [ADDR_W-1:0] wb_addr_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [31:0]       wr_count
);
  localparam int N = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs_q [N];
  logic [31:0]       cnt_q, cnt_d;
  logic              we;
  // a write commits only when enabled and not aimed at r0
  always_comb begin
    we    = wb_write_en_in && (wb_addr_in != ADDR_W'(ZERO_REG));
    cnt_d = we ? cnt_q + 32'd1 : cnt_q;
  end
  // register array and commit counter; reset wipes everything and drops any in-flight write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      if (we) regs_q[wb_addr_in] <= wb_data_in;
      cnt_q <= cnt_d;
    end
  end
  assign wr_count = cnt_q;
  reg_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_rs (
    .rst(rst), .rd_addr_i(rs_addr), .rf_data_i(regs_q[rs_addr]),
    .wb_en_i(wb_write_en_in), .wb_addr_i(wb_addr_in), .wb_data_i(wb_data_in),
    .rd_data_o(rs_data)
  );
  reg_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux_rt (
    .rst(rst), .rd_addr_i(rt_addr), .rf_data_i(regs_q[rt_addr]),
    .wb_en_i(wb_write_en_in), .wb_addr_i(wb_addr_in), .wb_data_i(wb_data_in),
    .rd_data_o(rt_data)
  );
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed and randomized checks of reg_file against an array-based reference model
module tb_reg_file;
  logic        clk = 0;
  logic        rst = 0;
  logic [31:0] wb_data_in = '0;
  logic        wb_write_en_in = 0;
  logic [4:0]  wb_addr_in = '0;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data, rt_data, wr_count;
  logic [31:0] m [32];
  logic [31:0] cnt;
  int          tests = 0;
  int          fails = 0;
  reg_file dut (
    .clk(clk), .rst(rst), .wb_data_in(wb_data_in), .wb_write_en_in(wb_write_en_in),
    .wb_addr_in(wb_addr_in), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] expect_rd(input logic en, input logic [4:0] wa,
                                            input logic [31:0] wd, input logic [4:0] ra);
    return (en && wa != 0 && ra == wa) ? wd : (ra == 0 ? 32'h0 : m[ra]);
  endfunction
  task automatic cyc(input logic en, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra, input logic [4:0] rb, input string tag);
    @(negedge clk);
    wb_write_en_in = en; wb_addr_in = wa; wb_data_in = wd; rs_addr = ra; rt_addr = rb;
    #1;
    check({tag, ".rs"}, rs_data, expect_rd(en, wa, wd, ra));
    check({tag, ".rt"}, rt_data, expect_rd(en, wa, wd, rb));
    @(posedge clk);
    if (en && wa != 0) begin
      m[wa] = wd;
      cnt   = cnt + 1;
    end
    #1;
    check({tag, ".cnt"}, wr_count, cnt);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) m[i] = '0;
    cnt = '0;
    #1;
    check("rst.rs", rs_data, 0);
    check("rst.cnt", wr_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    cyc(1, 5, 32'hDEADBEEF, 0, 0, "wr5");
    cyc(0, 0, 0, 5, 5, "rd5");
    check("rd5.cnt1", wr_count, 1);
    cyc(1, 0, 32'h12345678, 0, 0, "wr0");
    cyc(0, 0, 0, 0, 0, "rd0");
    check("rd0.cnt", wr_count, 1);
    cyc(1, 7, 32'h1, 0, 0, "wr7a");
    cyc(1, 7, 32'hCAFEF00D, 7, 7, "byp7");
    cyc(0, 9, 32'hFFFFFFFF, 9, 9, "dis9");
    cyc(0, 0, 0, 9, 7, "rd9");
    cyc(1, 1, 32'h11, 0, 0, "w1");
    cyc(1, 2, 32'h22, 0, 0, "w2");
    cyc(1, 3, 32'h33, 0, 0, "w3");
    @(negedge clk);
    wb_write_en_in = 1; wb_addr_in = 3; wb_data_in = 32'h99; rs_addr = 1; rt_addr = 3;
    #2;
    rst = 0;
    #1;
    check("arst.rs", rs_data, 0);
    check("arst.rt", rt_data, 0);
    check("arst.cnt", wr_count, 0);
    for (int i = 0; i < 32; i++) m[i] = '0;
    cnt = '0;
    @(negedge clk);
    wb_write_en_in = 0;
    rst = 1;
    cyc(0, 0, 0, 1, 2, "post1");
    cyc(0, 0, 0, 3, 3, "post3");
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    cnt = 32'hFFFF_FFFF;
    check("force.cnt", wr_count, cnt);
    cyc(1, 2, 32'h2222, 2, 0, "wrap");
    check("wrap.zero", wr_count, 0);
    for (int k = 0; k < 400; k++) begin
      logic        en;
      logic [4:0]  wa, ra, rb;
      en = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      ra = $urandom_range(0, 1) ? wa : 5'($urandom_range(0, 31));
      rb = $urandom_range(0, 1) ? wa : 5'($urandom_range(0, 31));
      cyc(en, wa, $urandom, ra, rb, "rnd");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
